fetch_if: RTL and testbench

FETCH_IF -- requirements
Module: fetch_if

---
 rtl/core_pkg.sv | 6 +
 rtl/fetch_queue.sv | 37 +++
 rtl/fetch_if.sv | 92 +++++++++
 tb/tb_fetch_if.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: fetch FSM states, NOP encoding and queue entry width shared by the core
package core_pkg;
    typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_FLUSH, ST_HALT} fetch_state_t;
    localparam logic [15:0] NOP_INSTR = 16'hffff;
    localparam int FQ_WIDTH = 48;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of {instr, next_pc} entries with synchronous clear
module fetch_queue #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign head = mem[rd_ptr];
    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/fetch_if.sv
// fetch_if: instruction fetch front end with one outstanding request and a credit-limited queue
module fetch_if
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        stall_pc_i,
    input  logic        stall_self_instr_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        end_program_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_valid_i,
    input  logic [15:0] imem_rdata_i,
    output logic [15:0] instr_o,
    output logic        instr_en_o,
    output logic [31:0] next_programm_counter_o,
    output logic        halted_o
);
    localparam int CW = $clog2(QDEPTH) + 1;
    fetch_state_t state;
    logic [31:0] pc;
    logic hold, outstanding, flush, resp, bypass, push, pop, issue;
    logic q_empty, q_full;
    logic [CW-1:0] q_cnt, q_cnt_nx;
    logic [FQ_WIDTH-1:0] q_head;

    assign hold = stall_i | stall_pc_i | stall_self_instr_i;
    assign outstanding = state == ST_WAIT || state == ST_FLUSH;
    assign flush = state == ST_HALT || branch_i || end_program_i;
    assign resp = state == ST_WAIT && imem_valid_i && !flush;
    assign bypass = resp && !hold && q_empty;
    assign push = resp && !bypass;
    assign pop = !flush && !hold && !q_empty;
    assign q_cnt_nx = q_cnt + CW'(push) - CW'(pop);
    // a new request may only go out if its response is guaranteed a queue slot
    assign issue = !rst_i && !flush && (!q_full || pop) && q_cnt_nx < CW'(QDEPTH)
                   && (state == ST_RUN || (outstanding && imem_valid_i));
    assign imem_req_o = issue;
    assign imem_addr_o = pc;
    assign halted_o = state == ST_HALT;

    fetch_queue #(.WIDTH(FQ_WIDTH), .DEPTH(QDEPTH)) u_queue (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear     (flush),
        .push      (push),
        .push_data ({imem_rdata_i, pc}),
        .pop       (pop),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_cnt)
    );

    // fetch pc already points past the outstanding request, so it is that response's next pc
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_RUN;
            pc <= RESET_PC;
            instr_o <= NOP_INSTR;
            instr_en_o <= 1'b0;
            next_programm_counter_o <= '0;
        end else if (state == ST_HALT) begin
            instr_en_o <= 1'b0;
        end else if (branch_i) begin
            state <= outstanding && !imem_valid_i ? ST_FLUSH : ST_RUN;
            pc <= branch_target_i;
            instr_en_o <= 1'b0;
        end else if (end_program_i) begin
            state <= ST_HALT;
            instr_en_o <= 1'b0;
        end else begin
            if (issue) begin
                state <= ST_WAIT;
                pc <= pc + 32'd2;
            end else if (outstanding && imem_valid_i) begin
                state <= ST_RUN;
            end
            if (!hold) begin
                instr_en_o <= bypass || pop;
                if (bypass) {instr_o, next_programm_counter_o} <= {imem_rdata_i, pc};
                else if (pop) {instr_o, next_programm_counter_o} <= q_head;
            end
        end
    end
endmodule

// File: tb/tb_fetch_if.sv
// tb_fetch_if: directed and randomized checks of fetch_if against a transaction-level model
module tb_fetch_if;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int QDEPTH = 2;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1, stall_i = 1'b0, stall_pc_i = 1'b0, stall_self_instr_i = 1'b0;
    logic branch_i = 1'b0, end_program_i = 1'b0, imem_valid_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic [15:0] imem_rdata_i = '0;
    logic imem_req_o, instr_en_o, halted_o;
    logic [31:0] imem_addr_o, next_programm_counter_o;
    logic [15:0] instr_o;

    always #5 clk_i = ~clk_i;

    fetch_if #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .stall_i                 (stall_i),
        .stall_pc_i              (stall_pc_i),
        .stall_self_instr_i      (stall_self_instr_i),
        .branch_i                (branch_i),
        .branch_target_i         (branch_target_i),
        .end_program_i           (end_program_i),
        .imem_req_o              (imem_req_o),
        .imem_addr_o             (imem_addr_o),
        .imem_valid_i            (imem_valid_i),
        .imem_rdata_i            (imem_rdata_i),
        .instr_o                 (instr_o),
        .instr_en_o              (instr_en_o),
        .next_programm_counter_o (next_programm_counter_o),
        .halted_o                (halted_o)
    );

    typedef struct {logic [31:0] addr; int due; bit live;} mreq_t;
    mreq_t mq[$];
    int tests = 0, fails = 0, cyc = 0, lat = 1;
    bit t_rst = 1'b1, t_stall, t_stall_pc, t_self, t_branch, t_end;
    logic [31:0] t_target = '0;
    logic [31:0] m_fetch, m_exp, p_npc;
    int m_avail = 0, pv_avail = 0, delivered = 0;
    bit m_halted = 1'b0, pv_rst = 1'b1, pv_flush, pv_hold;
    logic p_en;
    logic [15:0] p_instr;

    function automatic logic [15:0] mem_word(logic [31:0] a);
        return 16'h1000 + a[15:0];
    endfunction

    task automatic check(string tag, logic [47:0] got, logic [47:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock: drive inputs and memory after the edge, then check outputs at the falling edge
    task automatic step();
        bit flushing, hold;
        @(posedge clk_i);
        #1;
        cyc++;
        rst_i = t_rst; stall_i = t_stall; stall_pc_i = t_stall_pc; stall_self_instr_i = t_self;
        branch_i = t_branch; branch_target_i = t_target; end_program_i = t_end;
        imem_valid_i = 1'b0;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            imem_valid_i = 1'b1;
            imem_rdata_i = mem_word(mq[0].addr);
            if (mq[0].live) m_avail++;
            void'(mq.pop_front());
        end
        hold = t_stall | t_stall_pc | t_self;
        @(negedge clk_i);
        if (pv_rst) begin
            check("rst_en", instr_en_o, 0);
            check("rst_instr", instr_o, 16'hffff);
            check("rst_npc", next_programm_counter_o, 0);
            check("rst_halt", halted_o, 0);
        end else begin
            check("halted", halted_o, m_halted);
            if (pv_flush) check("flush_en", instr_en_o, 0);
            else if (pv_hold) begin
                check("hold_en", instr_en_o, p_en);
                check("hold_instr", instr_o, p_instr);
                check("hold_npc", next_programm_counter_o, p_npc);
            end else begin
                check("en", instr_en_o, pv_avail > 0);
                if (instr_en_o === 1'b1) begin
                    check("instr", instr_o, mem_word(m_exp));
                    check("npc", next_programm_counter_o, m_exp + 32'd2);
                    m_exp += 2;
                    m_avail--;
                    delivered++;
                end
            end
        end
        if (t_rst || m_halted) check("req_idle", imem_req_o, 0);
        else if (imem_req_o === 1'b1) begin
            check("one_outstanding", 48'(mq.size()), 0);
            check("req_addr", imem_addr_o, m_fetch);
            m_fetch += 2;
        end
        if (imem_req_o === 1'b1) mq.push_back('{addr: imem_addr_o, due: cyc + lat, live: 1'b1});
        flushing = t_rst || m_halted || t_branch || t_end;
        if (t_rst) begin
            m_fetch = RESET_PC;
            m_exp = RESET_PC;
            m_halted = 1'b0;
        end else if (!m_halted && t_branch) begin
            m_fetch = t_target;
            m_exp = t_target;
        end else if (t_end) m_halted = 1'b1;
        if (flushing) begin
            m_avail = 0;
            foreach (mq[i]) mq[i].live = 1'b0;
        end else check("buffered", 48'(m_avail <= QDEPTH + (hold ? 0 : 1)), 1);
        pv_rst = t_rst;
        pv_flush = flushing && !t_rst;
        pv_hold = hold;
        pv_avail = m_avail;
        p_en = instr_en_o;
        p_instr = instr_o;
        p_npc = next_programm_counter_o;
    endtask

    task automatic wait_req(string tag, int max);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            step();
            seen = imem_req_o;
        end
        check(tag, seen, 1);
    endtask

    task automatic wait_en(string tag, int max);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            step();
            seen = instr_en_o;
        end
        check(tag, seen, 1);
    endtask

    initial begin
        int n;
        logic [15:0] h;
        repeat (3) step();
        t_rst = 1'b0;
        step();
        check("d1_req0", {imem_req_o, imem_addr_o}, {1'b1, 32'h0});
        step();
        check("d1_req2", {imem_req_o, imem_addr_o, instr_en_o}, {1'b1, 32'h2, 1'b0});
        step();
        check("d1_out0", {instr_en_o, instr_o, next_programm_counter_o}, {1'b1, 16'h1000, 32'h2});
        check("d1_req4", {imem_req_o, imem_addr_o}, {1'b1, 32'h4});
        step();
        check("d1_out1", {instr_o, next_programm_counter_o}, {16'h1002, 32'h4});
        step();
        check("d1_out2", {instr_o, next_programm_counter_o}, {16'h1004, 32'h6});

        t_stall_pc = 1'b1;
        step();
        h = instr_o;
        step();
        check("d2_hold1", instr_o, h);
        step();
        check("d2_hold2", instr_o, h);
        t_stall_pc = 1'b0;
        step();
        check("d2_hold3", instr_o, h);
        repeat (6) step();

        lat = 3;
        wait_req("d3_first_req", 10);
        t_branch = 1'b1;
        t_target = 32'h40;
        step();
        t_branch = 1'b0;
        check("d3_outstanding", 48'(mq.size()), 1);
        wait_req("d3_req_after", 10);
        check("d3_addr", imem_addr_o, 32'h40);
        wait_en("d3_en", 10);
        check("d3_data", {instr_o, next_programm_counter_o}, {16'h1040, 32'h42});
        lat = 1;
        repeat (4) step();

        t_stall = 1'b1;
        wait_req("d4_req", 10);
        t_branch = 1'b1;
        t_target = 32'h80;
        step();
        t_branch = 1'b0;
        check("d4_valid_with_branch", imem_valid_i, 1);
        step();
        check("d4_en", instr_en_o, 0);
        check("d4_restart", {imem_req_o, imem_addr_o}, {1'b1, 32'h80});
        t_stall = 1'b0;
        repeat (6) step();

        n = delivered;
        for (int s = 0; s < 6; s++) begin
            lat = $urandom_range(1, 3);
            repeat (400) begin
                t_stall = $urandom_range(0, 99) < 10;
                t_stall_pc = $urandom_range(0, 99) < 10;
                t_self = $urandom_range(0, 99) < 10;
                t_branch = $urandom_range(0, 99) < 4;
                t_target = 32'($urandom_range(0, 4095)) << 1;
                step();
            end
        end
        t_stall = 1'b0; t_stall_pc = 1'b0; t_self = 1'b0; t_branch = 1'b0;
        lat = 1;
        repeat (8) step();
        check("rand_progress", 48'(delivered - n > 200), 1);

        t_end = 1'b1;
        step();
        t_end = 1'b0;
        n = 0;
        repeat (20) begin
            step();
            if (imem_req_o) n++;
        end
        check("d5_no_req", 48'(n), 0);
        check("d5_halted", {halted_o, instr_en_o}, {1'b1, 1'b0});

        lat = 2;
        t_rst = 1'b1;
        repeat (2) step();
        t_rst = 1'b0;
        wait_req("d6_req0", 5);
        wait_req("d6_req2", 5);
        t_rst = 1'b1;
        step();
        t_rst = 1'b0;
        step();
        check("d6_stale_arrives", imem_valid_i, 1);
        check("d6_restart", {imem_req_o, imem_addr_o}, {1'b1, RESET_PC});
        wait_en("d6_en", 8);
        check("d6_first", {instr_o, next_programm_counter_o}, {16'h1000, 32'h2});
        repeat (6) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
